// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - Opcodes, mode constant, state type and opcode decode helpers for the SRAM SPI responder
package sram_pkg;

  localparam logic [7:0] SRAM_NOP      = 8'h00;
  localparam logic [7:0] SRAM_WRMR     = 8'h01;
  localparam logic [7:0] SRAM_WRITE    = 8'h02;
  localparam logic [7:0] SRAM_READ     = 8'h03;
  localparam logic [7:0] SRAM_RDMR     = 8'h05;
  localparam logic [7:0] SRAM_SEQ_MODE = 8'h40;

  typedef enum logic [2:0] {INIT, IDLE, CMD, ADDR, DATA, CS_GAP, DONE} sram_state_t;

  function automatic logic op_supported(input logic [7:0] op);
    return (op == SRAM_READ) || (op == SRAM_WRITE) || (op == SRAM_WRMR) || (op == SRAM_RDMR);
  endfunction

  function automatic logic op_has_addr(input logic [7:0] op);
    return (op == SRAM_READ) || (op == SRAM_WRITE);
  endfunction

  function automatic logic op_is_write(input logic [7:0] op);
    return (op == SRAM_WRITE) || (op == SRAM_WRMR);
  endfunction

endpackage

// File: rtl/sram_spi_responder_sck_gen.sv
// rtl/sram_spi_responder_sck_gen.sv - SPI mode-0 clock: SCK_HALF clks low then high per bit
// rise_o/fall_o flag the cycle before the registered sck edge so callers can act on that same clk.
module sck_gen #(
  parameter int SCK_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(SCK_HALF);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          half_end;

  assign half_end = (cnt_q == CW'(SCK_HALF - 1));
  assign rise_o   = run_i & ~sck_q & half_end;
  assign fall_o   = run_i & sck_q & half_end;
  assign sck_o    = sck_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    sck_d = sck_q;
    if (!run_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (half_end) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/sram_spi_responder.sv
// rtl/sram_spi_responder.sv - One-command-at-a-time SPI master for a serial SRAM, bit-serial data port
// SRAM_SEQ_INIT_EN: after reset, write mode register 8'h40 (sequential) before accepting commands.
module sram_spi_responder
  import sram_pkg::*;
#(
  parameter int SCK_HALF = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  inst,
  input  logic [23:0] address,
  input  logic [23:0] byte_length,
  input  logic        write_in,
  output logic        mem_out,
  output logic        io_valid,
  output logic        rw_done,
  output logic        sram_cs_n,
  output logic        sram_sck,
  output logic        sram_mosi,
  input  logic        sram_miso
);

`ifdef SRAM_SEQ_INIT_EN
  localparam sram_state_t RESET_STATE = INIT;
`else
  localparam sram_state_t RESET_STATE = IDLE;
`endif
  localparam int GW = $clog2(SCK_HALF) + 1;

  sram_state_t   state_q, state_d;
  logic [26:0]   cnt_q, cnt_d;
  logic [30:0]   sh_q, sh_d;
  logic [7:0]    op_q, op_d;
  logic [23:0]   len_q, len_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          init_q, init_d, abort_q, abort_d;
  logic          cs_n_q, cs_n_d, mosi_q, mosi_d, mem_out_q, mem_out_d;
  logic          io_valid_q, io_valid_d, done_q, done_d;
  logic          run, sck_rise, sck_fall, last_bit;
  logic [26:0]   data_last;

  assign run       = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
  assign data_last = {len_q, 3'b000} - 27'd1;
  assign last_bit  = (state_q == CMD)  ? (cnt_q == 27'd7)  :
                     (state_q == ADDR) ? (cnt_q == 27'd23) : (cnt_q == data_last);

  sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (run),
    .sck_o  (sram_sck),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    op_d       = op_q;
    len_d      = len_q;
    gap_d      = gap_q;
    init_d     = init_q;
    abort_d    = abort_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    mem_out_d  = mem_out_q;
    io_valid_d = 1'b0;
    done_d     = done_q;
    unique case (state_q)
      INIT: begin
        op_d    = SRAM_WRMR;
        len_d   = 24'd1;
        sh_d    = {SRAM_WRMR[6:0], SRAM_SEQ_MODE, 16'h0000};
        init_d  = 1'b1;
        abort_d = 1'b0;
        cnt_d   = '0;
        cs_n_d  = 1'b0;
        mosi_d  = SRAM_WRMR[7];
        state_d = CMD;
      end
      IDLE: begin
        if (inst != SRAM_NOP) begin
          op_d    = inst;
          len_d   = byte_length;
          sh_d    = {inst[6:0], op_has_addr(inst) ? address : 24'h000000};
          init_d  = 1'b0;
          abort_d = 1'b0;
          cnt_d   = '0;
          if (op_supported(inst) && byte_length != 24'd0) begin
            cs_n_d  = 1'b0;
            mosi_d  = inst[7];
            state_d = CMD;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      CMD, ADDR, DATA: begin
        if (inst == SRAM_NOP && !init_q) abort_d = 1'b1;
        if (sck_rise && state_q == DATA && !op_is_write(op_q)) begin
          mem_out_d  = sram_miso;
          io_valid_d = 1'b1;
        end
        if (sck_fall) begin
          if (abort_d || (state_q == DATA && last_bit)) begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            gap_d   = '0;
            state_d = CS_GAP;
          end else begin
            // Command/address (and init data) shift out MSB first; reads clock out zeros.
            sh_d   = {sh_q[29:0], 1'b0};
            mosi_d = sh_q[30];
            if (last_bit) begin
              cnt_d   = '0;
              state_d = (state_q == CMD && op_has_addr(op_q)) ? ADDR : DATA;
            end else begin
              cnt_d = cnt_q + 27'd1;
            end
            if (state_d == DATA && op_is_write(op_q) && !init_q) begin
              mosi_d     = write_in;
              io_valid_d = 1'b1;
            end
          end
        end
      end
      CS_GAP: begin
        if (gap_q == GW'(SCK_HALF - 1)) begin
          init_d = 1'b0;
          if (abort_q || init_q) begin
            state_d = IDLE;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      DONE: begin
        if (inst == SRAM_NOP) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      sh_q       <= '0;
      op_q       <= SRAM_NOP;
      len_q      <= '0;
      gap_q      <= '0;
      init_q     <= 1'b0;
      abort_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      mem_out_q  <= 1'b0;
      io_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      op_q       <= op_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      init_q     <= init_d;
      abort_q    <= abort_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      mem_out_q  <= mem_out_d;
      io_valid_q <= io_valid_d;
      done_q     <= done_d;
    end
  end

  assign sram_cs_n = cs_n_q;
  assign sram_mosi = mosi_q;
  assign mem_out   = mem_out_q;
  assign io_valid  = io_valid_q;
  assign rw_done   = done_q;

endmodule

// File: tb/tb_sram_spi_responder.sv
// tb/tb_sram_spi_responder.sv - Directed bench with a serial SRAM bus model for sram_spi_responder
module tb_sram_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  inst = 8'h00;
  logic [23:0] address = 24'h0;
  logic [23:0] byte_length = 24'h0;
  logic        write_in = 1'b0;
  logic        mem_out, io_valid, rw_done, sram_cs_n, sram_sck, sram_mosi;
  logic        sram_miso = 1'b0;

  int checks = 0;
  int errors = 0;

  // SRAM bus model state
  logic [63:0] rx = '0, last_rx = '0;
  logic [7:0]  rdata = 8'hA5;
  int rises = 0, last_rises = 0, cs_falls = 0, cs_rises = 0;

  // run_cmd results
  int          io_cnt, done_gap;
  logic [31:0] rd_bits;

  always #5 clk = ~clk;

  sram_spi_responder #(.SCK_HALF(2)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .address(address), .byte_length(byte_length),
    .write_in(write_in), .mem_out(mem_out), .io_valid(io_valid), .rw_done(rw_done),
    .sram_cs_n(sram_cs_n), .sram_sck(sram_sck), .sram_mosi(sram_mosi), .sram_miso(sram_miso)
  );

  always @(negedge sram_cs_n) begin rises = 0; rx = '0; cs_falls++; end
  always @(posedge sram_cs_n) begin last_rises = rises; last_rx = rx; cs_rises++; end
  always @(posedge sram_sck) if (!sram_cs_n) begin rx = {rx[62:0], sram_mosi}; rises++; end
  always @(negedge sram_sck) if (!sram_cs_n && rises >= 32 && rises < 40) sram_miso = rdata[39-rises];

  task automatic run_cmd(input logic [7:0] op, input logic [23:0] a, input logic [23:0] len,
                         input logic [31:0] ws, output logic ok);
    int widx, cs_up;
    io_cnt = 0; rd_bits = '0; widx = 0; cs_up = -1; done_gap = -1; ok = 1'b0;
    write_in = ws[31];
    @(negedge clk);
    inst = op; address = a; byte_length = len;
    for (int cyc = 0; cyc < 3000 && !ok; cyc++) begin
      @(negedge clk);
      if (io_valid) begin
        io_cnt++;
        rd_bits = {rd_bits[30:0], mem_out};
        widx++;
        if (widx < 32) write_in = ws[31-widx];
      end
      if (!sram_cs_n) cs_up = -1;
      else if (cs_up < 0) cs_up = cyc;
      if (rw_done) begin ok = 1'b1; done_gap = cyc - cs_up; end
    end
  endtask

  task automatic wait_init;
`ifdef SRAM_SEQ_INIT_EN
    int base, vcnt;
    logic seen;
    base = cs_rises; vcnt = 0; seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (io_valid) vcnt++;
      if (cs_rises != base) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL init_done got %0b want 1", seen); end
    checks++; if (last_rises !== 16) begin errors++; $display("FAIL init_bits got %0d want 16", last_rises); end
    checks++; if (last_rx[15:0] !== 16'h0140) begin errors++; $display("FAIL init_wrmr got %h want 0140", last_rx[15:0]); end
    checks++; if (vcnt !== 0) begin errors++; $display("FAIL init_io_valid got %0d want 0", vcnt); end
`endif
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %b want 1", sram_cs_n); end
    checks++; if (sram_sck !== 1'b0) begin errors++; $display("FAIL rst_sck got %b want 0", sram_sck); end
    checks++; if (sram_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", sram_mosi); end
    checks++; if (mem_out !== 1'b0) begin errors++; $display("FAIL rst_mem_out got %b want 0", mem_out); end
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL rst_io_valid got %b want 0", io_valid); end
    checks++; if (rw_done !== 1'b0) begin errors++; $display("FAIL rst_rw_done got %b want 0", rw_done); end
    rst_n = 1'b1;
    wait_init();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read;
    logic ok;
    run_cmd(8'h03, 24'h000010, 24'd1, 32'h0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_done got %b want 1", ok); end
    checks++; if (last_rises !== 40) begin errors++; $display("FAIL read_rises got %0d want 40", last_rises); end
    checks++; if (last_rx[39:8] !== 32'h03000010) begin errors++; $display("FAIL read_mosi got %h want 03000010", last_rx[39:8]); end
    checks++; if (io_cnt !== 8) begin errors++; $display("FAIL read_io_valid got %0d want 8", io_cnt); end
    checks++; if (rd_bits[7:0] !== 8'hA5) begin errors++; $display("FAIL read_data got %h want a5", rd_bits[7:0]); end
    checks++; if (done_gap !== 2) begin errors++; $display("FAIL read_cs_gap got %0d want 2", done_gap); end
  endtask

  task automatic test_hold_done;
    int base, drops;
    base = cs_falls; drops = 0;
    repeat (20) begin
      @(negedge clk);
      if (rw_done !== 1'b1) drops++;
    end
    checks++; if (drops !== 0) begin errors++; $display("FAIL hold_rw_done drops got %0d want 0", drops); end
    checks++; if (cs_falls !== base) begin errors++; $display("FAIL hold_no_retrigger got %0d want %0d", cs_falls, base); end
    inst = 8'h00;
    @(negedge clk);
    checks++; if (rw_done !== 1'b0) begin errors++; $display("FAIL hold_clear got %b want 0", rw_done); end
  endtask

  task automatic test_write;
    logic ok;
    run_cmd(8'h02, 24'h01FFFF, 24'd2, 32'hBEEF0000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL write_done got %b want 1", ok); end
    checks++; if (last_rises !== 48) begin errors++; $display("FAIL write_rises got %0d want 48", last_rises); end
    checks++; if (last_rx[47:40] !== 8'h02) begin errors++; $display("FAIL write_cmd got %h want 02", last_rx[47:40]); end
    checks++; if (last_rx[39:16] !== 24'h01FFFF) begin errors++; $display("FAIL write_addr got %h want 01ffff", last_rx[39:16]); end
    checks++; if (last_rx[15:0] !== 16'hBEEF) begin errors++; $display("FAIL write_data got %h want beef", last_rx[15:0]); end
    checks++; if (io_cnt !== 16) begin errors++; $display("FAIL write_io_valid got %0d want 16", io_cnt); end
    checks++; if (done_gap !== 2) begin errors++; $display("FAIL write_cs_gap got %0d want 2", done_gap); end
    inst = 8'h00;
    @(negedge clk);
    checks++; if (rw_done !== 1'b0) begin errors++; $display("FAIL write_clear got %b want 0", rw_done); end
  endtask

  task automatic test_reject;
    int base;
    base = cs_falls;
    inst = 8'h7F; byte_length = 24'd1;
    repeat (2) @(negedge clk);
    checks++; if (rw_done !== 1'b1) begin errors++; $display("FAIL bad_op_done got %b want 1", rw_done); end
    inst = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (rw_done !== 1'b0) begin errors++; $display("FAIL bad_op_clear got %b want 0", rw_done); end
    inst = 8'h03; byte_length = 24'd0;
    repeat (2) @(negedge clk);
    checks++; if (rw_done !== 1'b1) begin errors++; $display("FAIL zero_len_done got %b want 1", rw_done); end
    checks++; if (cs_falls !== base) begin errors++; $display("FAIL reject_cs_n got %0d want %0d", cs_falls, base); end
    inst = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort;
    logic ok, reached;
    int done_seen;
    reached = 1'b0; done_seen = 0;
    @(negedge clk);
    inst = 8'h03; address = 24'h000010; byte_length = 24'd1;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clk);
      if (rises == 20 && !sram_cs_n) reached = 1'b1;
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("FAIL abort_reach got %b want 1", reached); end
    inst = 8'h00;
    repeat (20) begin
      @(negedge clk);
      if (rw_done) done_seen++;
    end
    checks++; if (last_rises !== 20) begin errors++; $display("FAIL abort_rises got %0d want 20", last_rises); end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_rw_done got %0d want 0", done_seen); end
    run_cmd(8'h03, 24'h000010, 24'd1, 32'h0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reread_done got %b want 1", ok); end
    checks++; if (last_rises !== 40) begin errors++; $display("FAIL reread_rises got %0d want 40", last_rises); end
    checks++; if (rd_bits[7:0] !== 8'hA5) begin errors++; $display("FAIL reread_data got %h want a5", rd_bits[7:0]); end
    inst = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic reached, ok;
    reached = 1'b0; ok = 1'b0;
    @(negedge clk);
    inst = 8'h03; address = 24'h000010; byte_length = 24'd1;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clk);
      if (rises == 36 && !sram_cs_n) reached = 1'b1;
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("FAIL mid_reach got %b want 1", reached); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_n got %b want 1", sram_cs_n); end
    checks++; if (sram_sck !== 1'b0) begin errors++; $display("FAIL mid_sck got %b want 0", sram_sck); end
    checks++; if (sram_mosi !== 1'b0) begin errors++; $display("FAIL mid_mosi got %b want 0", sram_mosi); end
    checks++; if ({io_valid, rw_done, mem_out} !== 3'b000) begin errors++; $display("FAIL mid_outs got %b want 000", {io_valid, rw_done, mem_out}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (rw_done) ok = 1'b1;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL post_rst_done got %b want 1", ok); end
    checks++; if (last_rises !== 40) begin errors++; $display("FAIL post_rst_rises got %0d want 40", last_rises); end
    checks++; if (last_rx[39:8] !== 32'h03000010) begin errors++; $display("FAIL post_rst_mosi got %h want 03000010", last_rx[39:8]); end
    inst = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_hold_done();
    test_write();
    test_reject();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_spi_responder.md
Name: sram_spi_responder

Overview:
Responder side of the per-channel SRAM command interface driven by the task manager and its task engines. It accepts one command (inst/address/byte_length), runs it as an SPI mode-0 transaction on one serial SRAM (23LC1024-class, 24-bit address field), and streams data one bit at a time. For writes it consumes bits from write_in; for reads it returns bits on mem_out, with an io_valid strobe per bit. It signals completion on rw_done. Four instances sit between the task manager and the four SRAM chips.

Parameters:
SCK_HALF, 2, clk cycles per SCK half-period; legal range >= 2; SCK frequency = clk / (2*SCK_HALF)

Ports:
clk  input  1  system clock; all logic on posedge clk
rst_n  input  1  asynchronous, active-low reset
inst  input  8  SRAM opcode; 8'h00 = no request
address  input  24  start address; sent MSB first
byte_length  input  24  number of data bytes
write_in  input  1  next write data bit, MSB first per byte
mem_out  output  1  last read data bit
io_valid  output  1  one-cycle strobe per data bit (write bit consumed / mem_out updated)
rw_done  output  1  transaction complete; level
sram_cs_n  output  1  SPI chip select, active low
sram_sck  output  1  SPI clock, idle low
sram_mosi  output  1  SPI data to SRAM
sram_miso  input  1  SPI data from SRAM

Behaviour:
- Reset (asynchronous, immediate): sram_cs_n=1, sram_sck=0, sram_mosi=0, mem_out=0, io_valid=0, rw_done=0; state goes to INIT if SRAM_SEQ_INIT_EN is defined, otherwise IDLE. Reset mid-transaction aborts it with no further SCK edges.
- Opcodes: READ 8'h03 (cmd+addr+data in), WRITE 8'h02 (cmd+addr+data out), WRMR 8'h01 and RDMR 8'h05 (cmd+data, no address phase).
- IDLE: a nonzero inst is latched together with address and byte_length.
  - Unsupported opcode or byte_length==0: go directly to DONE; cs_n is never asserted.
  - Otherwise, the cycle after acceptance: cs_n=0, mosi=inst[7], go to CMD.
- SPI timing: mosi changes only while SCK is low; each bit holds SCK low for SCK_HALF clks, then high for SCK_HALF clks; miso is sampled on the clk where SCK rises.
- CMD: 8 bits, then ADDR (READ/WRITE) or DATA. ADDR: 24 bits, MSB first.
- DATA: 8*byte_length bits; the bit counter is 27 bits wide; there is no address wrap logic (the SRAM's sequential mode handles it).
  - Write: write_in is sampled on the clk it is loaded onto mosi; io_valid pulses on the next clk. The requester advances write_in after each io_valid.
  - Read: mem_out<=miso on the SCK-rise clk; io_valid pulses in that same cycle.
- After the last SCK falling edge: CS_GAP, with cs_n=1 and sck=0 for SCK_HALF clks, then DONE.
- DONE: rw_done=1, held until inst==8'h00, then rw_done=0 on the next clk and return to IDLE. A new command needs inst to pass through 8'h00.
- Abort: if inst becomes 8'h00 during CMD/ADDR/DATA, finish the current SCK period, go to CS_GAP, and skip rw_done (go straight to IDLE).
- The inputs address, byte_length and write_in (data phase only) are ignored after acceptance except as stated above.

Optional Feature:
SRAM_SEQ_INIT_EN
- Defined: after reset the state is INIT, which issues WRMR 8'h01 with data 8'h40 (sequential mode) internally, with no io_valid and no rw_done, then goes through CS_GAP to IDLE. Commands are ignored until INIT completes.
- Undefined: reset lands directly in IDLE; the task engine must issue WRMR itself.

Decomposition:
- Package sram_pkg:
  - opcode constants SRAM_READ/SRAM_WRITE/SRAM_WRMR/SRAM_RDMR/SRAM_NOP
  - SRAM_SEQ_MODE=8'h40
  - state enum typedef sram_state_t (INIT, IDLE, CMD, ADDR, DATA, CS_GAP, DONE)
- One sub-module: sck_gen, a half-period counter that outputs sck plus one-cycle rise/fall enables, with a run input.

Test Plan:
- READ, addr 24'h000010, len 1, SCK_HALF=2, SRAM model holds 8'hA5 → 40 SCK rises; mosi shows 8'h03 then 24'h000010; 8 io_valid pulses with mem_out 1,0,1,0,0,1,0,1; then rw_done=1.
- WRITE, addr 24'h01FFFF, len 2, write stream 16'hBEEF → model receives 8'hBE,8'hEF; 16 io_valid pulses; cs_n high for 2 clks before rw_done; rw_done clears one clk after inst=0.
- inst=8'h7F or byte_length=0 → no cs_n activity; rw_done=1 within 2 clks.
- inst held at 8'h03 after DONE → rw_done stays 1, with no second transaction until inst=0 then 8'h03.
- inst dropped to 0 after 20 SCK rises of a READ → cs_n rises after the current SCK period; rw_done never set; the next READ works.
- rst_n low mid-DATA, then released with SRAM_SEQ_INIT_EN defined → outputs reset immediately; a WRMR 8'h01,8'h40 appears on the bus before any user command is accepted.
